// File: rtl/program_load_sequencer_if.sv
// Loader/sequencer bus: byte stream in, imem write port and run control out.
// master = loader/PC side (drives start, bytes, finished); slave = sequencer.
interface program_load_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  startProgramLoading;
  logic [7:0]            byteIn;
  logic                  byteValid;
  logic                  byteReady;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [31:0]           imemData;
  logic                  imemWe;
  logic                  programLoaded;
  logic                  programStart;
  logic                  programFinished;
  logic [ADDR_WIDTH:0]   wordCount;
  logic                  loadError;

  modport master (
    output startProgramLoading, byteIn, byteValid,
    output programFinished,
    input  byteReady, imemAddr, imemData, imemWe,
    input  programLoaded, programStart, wordCount,
    input  loadError
  );

  modport slave (
    input  startProgramLoading, byteIn, byteValid,
    input  programFinished,
    output byteReady, imemAddr, imemData, imemWe,
    output programLoaded, programStart, wordCount,
    output loadError
  );
endinterface

// File: rtl/program_load_sequencer.sv
// Program load sequencer: parses N(16b BE) + N BE words into imem, then runs.
// Ports: clock, reset (async low), bus (slave). Macro PROGRAM_CHECKSUM_EN adds XOR trailer.
module program_load_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input logic clock,
  input logic reset,
  program_load_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LOAD, S_WRITE, S_CHK,
    S_READY, S_RUN, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic                  r_hdr_hi;
  logic [15:0]           r_n;
  logic [1:0]            r_bcnt;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH:0]   r_count;
`ifdef PROGRAM_CHECKSUM_EN
  logic [7:0]            r_xsum;
`endif

  logic                  w_xfer;
  logic                  w_idle_like;
  logic                  w_start;
  logic [15:0]           w_hdr_n;
  logic                  w_hdr_bad;
  logic [ADDR_WIDTH:0]   w_cnt_inc;
  logic                  w_last;

  assign w_xfer      = bus.byteValid & bus.byteReady;
  assign w_idle_like = (r_state == S_IDLE)  || (r_state == S_READY) ||
                       (r_state == S_RUN)   || (r_state == S_DONE)  ||
                       (r_state == S_ERROR);
  assign w_start     = bus.startProgramLoading & w_idle_like;
  assign w_hdr_n     = {r_n[15:8], bus.byteIn};
  assign w_hdr_bad   = (w_hdr_n == 16'd0) || ({1'b0, w_hdr_n} > LP_MAX);
  assign w_cnt_inc   = r_count + 1'b1;
  // count after this write vs. header length
  assign w_last      = (32'(w_cnt_inc) == 32'(r_n));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start) w_next = S_HDR;
      end
      S_READY: w_next = w_start ? S_HDR : S_RUN;
      S_RUN: begin
        if (w_start)                  w_next = S_HDR;
        else if (bus.programFinished) w_next = S_DONE;
      end
      S_HDR: begin
        if (w_xfer && r_hdr_hi)
          w_next = w_hdr_bad ? S_ERROR : S_LOAD;
      end
      S_LOAD: begin
        if (w_xfer && r_bcnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
`ifdef PROGRAM_CHECKSUM_EN
        w_next = w_last ? S_CHK : S_LOAD;
`else
        w_next = w_last ? S_READY : S_LOAD;
`endif
      end
      S_CHK: begin
`ifdef PROGRAM_CHECKSUM_EN
        if (w_xfer)
          w_next = (bus.byteIn == r_xsum) ? S_READY : S_ERROR;
`else
        w_next = S_ERROR;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hdr_hi <= 1'b0;
      r_n      <= '0;
      r_bcnt   <= '0;
      r_word   <= '0;
      r_count  <= '0;
`ifdef PROGRAM_CHECKSUM_EN
      r_xsum   <= '0;
`endif
    end else if (w_start) begin
      r_hdr_hi <= 1'b0;
      r_bcnt   <= '0;
      r_count  <= '0;
`ifdef PROGRAM_CHECKSUM_EN
      r_xsum   <= '0;
`endif
    end else if (r_state == S_HDR && w_xfer) begin
      if (!r_hdr_hi) r_n[15:8] <= bus.byteIn;
      else           r_n[7:0]  <= bus.byteIn;
      r_hdr_hi <= ~r_hdr_hi;
    end else if (r_state == S_LOAD && w_xfer) begin
      r_word <= {r_word[23:0], bus.byteIn};
      r_bcnt <= r_bcnt + 2'd1;
`ifdef PROGRAM_CHECKSUM_EN
      r_xsum <= r_xsum ^ bus.byteIn;
`endif
    end else if (r_state == S_WRITE) begin
      r_count <= w_cnt_inc;
    end
  end

  assign bus.byteReady     = (r_state == S_HDR) || (r_state == S_LOAD) ||
                             (r_state == S_CHK);
  assign bus.imemWe        = (r_state == S_WRITE);
  assign bus.imemAddr      = r_count[ADDR_WIDTH-1:0];
  assign bus.imemData      = r_word;
  assign bus.wordCount     = r_count;
  assign bus.programLoaded = (r_state == S_READY) || (r_state == S_RUN) ||
                             (r_state == S_DONE);
  assign bus.programStart  = (r_state == S_RUN);
  assign bus.loadError     = (r_state == S_ERROR);

endmodule

// File: doc/program_load_sequencer.md
PROGRAM_LOAD_SEQUENCER -- requirements
Module: program_load_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 256: largest legal program length in words, at most 2^ADDR_WIDTH.
REQ-003 Port clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port startProgramLoading  in  1  one-cycle pulse that begins a load.
REQ-006 Port byteIn  in  8  loader byte stream.
REQ-007 Port byteValid  in  1  byteIn is valid.
REQ-008 Port byteReady  out  1  sequencer accepts a byte; a transfer occurs when byteValid and byteReady are both high.
REQ-009 Port imemAddr  out  ADDR_WIDTH  instruction-memory write address.
REQ-010 Port imemData  out  32  instruction-memory write data.
REQ-011 Port imemWe  out  1  instruction-memory write strobe.
REQ-012 Port programLoaded  out  1  a complete, valid program is resident.
REQ-013 Port programStart  out  1  run enable to the PC path.
REQ-014 Port programFinished  in  1  the running program has completed.
REQ-015 Port wordCount  out  ADDR_WIDTH+1  number of words written in the current load.
REQ-016 Port loadError  out  1  the last load was rejected.

Function
REQ-017 States SHALL be IDLE, HDR, LOAD, WRITE, CHK, READY, RUN, DONE and ERROR.
REQ-018 Stream format SHALL be a 16-bit big-endian word count N, then N words of 4 bytes each, big-endian.
REQ-019 startProgramLoading SHALL move the sequencer from any state except HDR, LOAD, WRITE or CHK to HDR, and SHALL clear wordCount, loadError and programLoaded.
REQ-020 byteReady SHALL be high only in HDR, LOAD and CHK.
REQ-021 In HDR, after two bytes are accepted: if N==0 or N>MAX_WORDS the sequencer SHALL go to ERROR; otherwise it SHALL go to LOAD.
REQ-022 In LOAD, the fourth accepted byte of a word SHALL cause a transition to WRITE.
REQ-023 The WRITE state SHALL last exactly one cycle, with imemWe=1, imemAddr=wordCount[ADDR_WIDTH-1:0] and imemData equal to the assembled word.
REQ-024 On leaving WRITE, wordCount SHALL increment; if wordCount equals N the next state SHALL be CHK (macro defined) or READY (macro undefined), otherwise LOAD.
REQ-025 READY SHALL assert programLoaded and SHALL move to RUN on the following cycle.
REQ-026 RUN SHALL hold programStart=1 and programLoaded=1 until programFinished=1 is sampled, then go to DONE.
REQ-027 DONE SHALL hold programLoaded=1 and programStart=0; startProgramLoading reloads from DONE.
REQ-028 ERROR SHALL hold loadError=1 and programLoaded=0; only startProgramLoading or reset leaves it.
REQ-029 startProgramLoading in HDR, LOAD, WRITE or CHK SHALL be ignored.
REQ-030 If startProgramLoading and byteValid are both high in IDLE, READY, RUN, DONE or ERROR, the start SHALL win and no byte SHALL be accepted that cycle.
REQ-031 Outside WRITE, imemWe SHALL be 0.
REQ-032 Partial byte assembly SHALL be discarded on reset.

Reset
REQ-033 Asserting reset low SHALL immediately force state to IDLE.
REQ-034 While reset is low, byteReady, imemWe, programLoaded, programStart and loadError SHALL be 0, and imemAddr, imemData and wordCount SHALL be all-zeros.
REQ-035 Reset asserted mid-load SHALL abandon the load, and no further imemWe pulse SHALL occur until the next load.

Configuration
REQ-036 Macro PROGRAM_CHECKSUM_EN, when defined, SHALL enable state CHK: one trailing byte is accepted and compared with the XOR of all 4N data bytes; a match goes to READY, a mismatch to ERROR.
REQ-037 Without PROGRAM_CHECKSUM_EN, CHK SHALL be unreachable, no trailing byte SHALL be consumed, and WRITE of word N SHALL go directly to READY.

Verification
REQ-038 Reset low mid-LOAD -> all outputs 0 at once; state IDLE after release; no imemWe pulse.
REQ-039 Pulse start; stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> imemWe at addr 0 with 0x12345678, then at addr 1 with 0x9ABCDEF0; programLoaded=1, programStart=1 one cycle later; wordCount=2.
REQ-040 In RUN, raise programFinished for 1 cycle -> programStart=0 next cycle, programLoaded stays 1 (DONE).
REQ-041 Header 00 00, then header 01 01 with MAX_WORDS=256 -> loadError=1 each time, no imemWe pulse.
REQ-042 With PROGRAM_CHECKSUM_EN, one word 01 02 04 08 with trailer 0F -> READY; same word with trailer 0E -> ERROR, programLoaded=0.
REQ-043 In IDLE, drive start and byteValid together -> byteReady=0 that cycle, state HDR next cycle; the byte is consumed on the following cycle.
